// File: rtl/hms_counter.sv
// hms_counter: time-of-day seconds/minutes/hours counter with field set and midnight day_tick
module hms_counter #(
  parameter int HOURS_PER_DAY = 24,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_1hz,
  input  logic         set_en,
  input  logic [1:0]   set_sel,
  input  logic [W-1:0] set_val,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hour,
  output logic         day_tick,
  output logic         set_ack,
  output logic         set_err
);
  localparam logic [W-1:0] MAX_MS = W'(59);
  localparam logic [W-1:0] MAX_H = W'(HOURS_PER_DAY - 1);
  logic [W-1:0] sec_inc, min_inc, hour_inc;
  logic sec_wrap, min_wrap, hour_wrap, legal;
  always_comb begin
    sec_inc = sec + 1'b1;
    min_inc = min + 1'b1;
    hour_inc = hour + 1'b1;
    sec_wrap = sec == MAX_MS;
    min_wrap = min == MAX_MS;
    hour_wrap = hour == MAX_H;
    legal = (set_sel == 2'd0) ? set_val <= MAX_MS :
            (set_sel == 2'd1) ? set_val <= MAX_MS :
            (set_sel == 2'd2) ? set_val <= MAX_H : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sec <= '0;
      min <= '0;
      hour <= '0;
      day_tick <= 1'b0;
      set_ack <= 1'b0;
      set_err <= 1'b0;
    end else begin
      day_tick <= 1'b0;
      set_ack <= set_en && legal;
      set_err <= set_en && !legal;
      if (set_en) begin
        sec <= (legal && set_sel == 2'd0) ? set_val : sec;
        min <= (legal && set_sel == 2'd1) ? set_val : min;
        hour <= (legal && set_sel == 2'd2) ? set_val : hour;
      end else if (tick_1hz) begin
        sec <= sec_wrap ? '0 : sec_inc;
        if (sec_wrap) min <= min_wrap ? '0 : min_inc;
        if (sec_wrap && min_wrap) hour <= hour_wrap ? '0 : hour_inc;
        day_tick <= sec_wrap && min_wrap && hour_wrap;
      end
    end
  end
endmodule

// File: tb/tb_hms_counter.sv
// tb_hms_counter: randomized check of 24 h and 12 h builds against a seconds-of-day model
module tb_hms_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, tick_1hz, set_en;
  logic [1:0] set_sel;
  logic [5:0] set_val;
  logic [5:0] sec24, min24, hour24, sec12, min12, hour12;
  logic dt24, ack24, err24, dt12, ack12, err12;
  int checks = 0;
  int errors = 0;
  int t24 = 0;
  int t12 = 0;
  hms_counter #(.HOURS_PER_DAY(24), .W(6)) u24 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_en(set_en), .set_sel(set_sel),
    .set_val(set_val), .sec(sec24), .min(min24), .hour(hour24), .day_tick(dt24),
    .set_ack(ack24), .set_err(err24)
  );
  hms_counter #(.HOURS_PER_DAY(12), .W(6)) u12 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_en(set_en), .set_sel(set_sel),
    .set_val(set_val), .sec(sec12), .min(min12), .hour(hour12), .day_tick(dt12),
    .set_ack(ack12), .set_err(err12)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit r, input bit tk, input bit se, input logic [1:0] sel,
                       input logic [5:0] val, input int hpd, inout int t,
                       output bit dt, output bit ack, output bit err);
    int hh, mm, ss;
    bit ok;
    dt = 0;
    ack = 0;
    err = 0;
    if (r) t = 0;
    else if (se) begin
      ok = (sel == 0 || sel == 1) ? val < 60 : (sel == 2) ? val < hpd : 0;
      hh = t / 3600;
      mm = (t / 60) % 60;
      ss = t % 60;
      if (ok && sel == 0) ss = val;
      if (ok && sel == 1) mm = val;
      if (ok && sel == 2) hh = val;
      t = hh * 3600 + mm * 60 + ss;
      ack = ok;
      err = !ok;
    end else if (tk) begin
      t = (t + 1) % (hpd * 3600);
      dt = t == 0;
    end
  endtask
  task automatic step(input bit r, input bit tk, input bit se, input logic [1:0] sel,
                      input logic [5:0] val);
    bit dt, ack, err;
    reset = r;
    tick_1hz = tk;
    set_en = se;
    set_sel = sel;
    set_val = val;
    @(posedge clk);
    #1;
    model(r, tk, se, sel, val, 24, t24, dt, ack, err);
    check("sec24", sec24, t24 % 60);
    check("min24", min24, (t24 / 60) % 60);
    check("hour24", hour24, t24 / 3600);
    check("day_tick24", dt24, dt);
    check("set_ack24", ack24, ack);
    check("set_err24", err24, err);
    model(r, tk, se, sel, val, 12, t12, dt, ack, err);
    check("sec12", sec12, t12 % 60);
    check("min12", min12, (t12 / 60) % 60);
    check("hour12", hour12, t12 / 3600);
    check("day_tick12", dt12, dt);
    check("set_ack12", ack12, ack);
    check("set_err12", err12, err);
  endtask
  task automatic tick();
    step(0, 1, 0, 2'd0, 6'd0);
  endtask
  task automatic idle();
    step(0, 0, 0, 2'd0, 6'd0);
  endtask
  task automatic set_f(input logic [1:0] sel, input logic [5:0] val);
    step(0, 0, 1, sel, val);
  endtask
  task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    set_f(2'd2, h);
    set_f(2'd1, m);
    set_f(2'd0, s);
  endtask
  initial begin
    step(1, 0, 0, 2'd0, 6'd0);
    repeat (3) tick();
    set_f(2'd0, 6'd59);
    set_f(2'd1, 6'd12);
    tick();
    set_time(6'd23, 6'd59, 6'd59);
    tick();
    idle();
    set_time(6'd11, 6'd59, 6'd59);
    tick();
    idle();
    set_f(2'd1, 6'd60);
    set_f(2'd3, 6'd5);
    set_f(2'd2, 6'd24);
    set_f(2'd2, 6'd12);
    set_f(2'd2, 6'd7);
    set_time(6'd10, 6'd20, 6'd30);
    step(0, 1, 1, 2'd0, 6'd5);
    set_time(6'd11, 6'd59, 6'd59);
    step(0, 1, 1, 2'd1, 6'd63);
    idle();
    set_time(6'd12, 6'd34, 6'd56);
    step(1, 1, 0, 2'd0, 6'd0);
    tick();
    set_time(6'd23, 6'd59, 6'd57);
    repeat (6) tick();
    repeat (3000) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           2'($urandom), 6'($urandom_range(0, 63)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
